// File: rtl/axi_mem_arbiter_pkg.sv
// Shared FSM state types, AXI encodings and default IDs for axi_mem_arbiter.
package arb_pkg;
  typedef enum logic {AR_IDLE, AR_BUSY} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] DEF_ICACHE_ID  = 4'b0000;
  localparam logic [3:0] DEF_DCACHE_ID  = 4'b0001;
endpackage

// File: rtl/axi_mem_arbiter_if.sv
// AXI3 master-side bus bundle; master = arbiter, slave = interconnect.
interface axi_mem_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_mem_arbiter_rr.sv
// Two-way read arbiter: req/gnt bit 0 = icache, bit 1 = dcache.
// ARB_ROUND_ROBIN_EN builds an alternating last_grant; otherwise dcache has fixed priority.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);
`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;  // 1 = dcache won the last grant

  always_comb begin
    gnt          = req;
    last_grant_d = last_grant_q;
    if (req == 2'b11) gnt = last_grant_q ? 2'b01 : 2'b10;
    if (update && (gnt != 2'b00)) last_grant_d = gnt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b0;
    else        last_grant_q <= last_grant_d;
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, update};
  assign gnt       = {req[1], req[0] & ~req[1]};
`endif
endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one AXI3 master between icache reads and dcache reads/single-beat writes.
// Define ARB_ROUND_ROBIN_EN for alternating read arbitration (default: dcache priority).
module axi_mem_arbiter
  import arb_pkg::*;
#(
  parameter logic [3:0] ICACHE_ID = DEF_ICACHE_ID,
  parameter logic [3:0] DCACHE_ID = DEF_DCACHE_ID
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rd_req,
  input  logic [31:0] i_rd_addr,
  input  logic [7:0]  i_rd_len,
  output logic        i_rd_gnt,
  output logic        i_rd_valid,
  output logic [31:0] i_rd_data,
  output logic        i_rd_last,
  input  logic        d_rd_req,
  input  logic [31:0] d_rd_addr,
  input  logic [7:0]  d_rd_len,
  output logic        d_rd_gnt,
  output logic        d_rd_valid,
  output logic [31:0] d_rd_data,
  output logic        d_rd_last,
  input  logic        d_wr_req,
  input  logic [31:0] d_wr_addr,
  input  logic [31:0] d_wr_data,
  input  logic [3:0]  d_wr_strb,
  output logic        d_wr_gnt,
  output logic        d_wr_done,
  axi_mem_arbiter_if.master axi
);
  ar_state_t   ar_state_q, ar_state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [3:0]  arid_q, arid_d;
  logic        ar_dsel_q, ar_dsel_d;
  logic        i_out_q, i_out_d, d_out_q, d_out_d;

  w_state_t    w_state_q, w_state_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;

  logic [1:0]  arb_req, arb_gnt;
  logic        unused_axi;

  // dcache reads wait for the write path to drain to keep read-after-write order
  assign arb_req[0] = (ar_state_q == AR_IDLE) && i_rd_req && !i_out_q;
  assign arb_req[1] = (ar_state_q == AR_IDLE) && d_rd_req && !d_out_q && (w_state_q == W_IDLE);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (arb_req),
    .update (|arb_gnt),
    .gnt    (arb_gnt)
  );

  assign i_rd_gnt = arb_gnt[0];
  assign d_rd_gnt = arb_gnt[1];

  always_comb begin
    ar_state_d = ar_state_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arid_d     = arid_q;
    ar_dsel_d  = ar_dsel_q;
    i_out_d    = i_out_q;
    d_out_d    = d_out_q;
    if (axi.rvalid && axi.rlast && (axi.rid == ICACHE_ID)) i_out_d = 1'b0;
    if (axi.rvalid && axi.rlast && (axi.rid == DCACHE_ID)) d_out_d = 1'b0;
    case (ar_state_q)
      AR_IDLE: begin
        if (arb_gnt[1]) begin
          araddr_d   = d_rd_addr;
          arlen_d    = d_rd_len;
          arid_d     = DCACHE_ID;
          ar_dsel_d  = 1'b1;
          ar_state_d = AR_BUSY;
        end else if (arb_gnt[0]) begin
          araddr_d   = i_rd_addr;
          arlen_d    = i_rd_len;
          arid_d     = ICACHE_ID;
          ar_dsel_d  = 1'b0;
          ar_state_d = AR_BUSY;
        end
      end
      AR_BUSY: begin
        if (axi.arready) begin
          if (ar_dsel_q) d_out_d = 1'b1;
          else           i_out_d = 1'b1;
          ar_state_d = AR_IDLE;
        end
      end
      default: ar_state_d = AR_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    d_wr_gnt  = 1'b0;
    d_wr_done = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (d_wr_req) begin
          d_wr_gnt  = 1'b1;
          awaddr_d  = d_wr_addr;
          wdata_d   = d_wr_data;
          wstrb_d   = d_wr_strb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_XFER;
        end
      end
      W_XFER: begin
        if ((aw_done_q || axi.awready) && (w_done_q || axi.wready)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_RESP;
        end else begin
          aw_done_d = aw_done_q || axi.awready;
          w_done_d  = w_done_q || axi.wready;
        end
      end
      W_RESP: begin
        if (axi.bvalid) begin
          d_wr_done = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_state_q <= AR_IDLE;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arid_q     <= '0;
      ar_dsel_q  <= 1'b0;
      i_out_q    <= 1'b0;
      d_out_q    <= 1'b0;
      w_state_q  <= W_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      ar_state_q <= ar_state_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arid_q     <= arid_d;
      ar_dsel_q  <= ar_dsel_d;
      i_out_q    <= i_out_d;
      d_out_q    <= d_out_d;
      w_state_q  <= w_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = AXI_SIZE_4B;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arlock  = '0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;
  assign axi.arvalid = (ar_state_q == AR_BUSY);

  assign axi.rready  = 1'b1;
  assign i_rd_valid  = axi.rvalid && (axi.rid == ICACHE_ID);
  assign d_rd_valid  = axi.rvalid && (axi.rid == DCACHE_ID);
  assign i_rd_data   = axi.rdata;
  assign d_rd_data   = axi.rdata;
  assign i_rd_last   = axi.rlast;
  assign d_rd_last   = axi.rlast;

  assign axi.awid    = DCACHE_ID;
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = '0;
  assign axi.awsize  = AXI_SIZE_4B;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awlock  = '0;
  assign axi.awcache = '0;
  assign axi.awprot  = '0;
  assign axi.awvalid = (w_state_q == W_XFER) && !aw_done_q;

  assign axi.wid     = DCACHE_ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = (w_state_q == W_XFER) && !w_done_q;
  assign axi.wlast   = axi.wvalid;

  assign axi.bready  = (w_state_q == W_RESP);
  assign unused_axi  = ^{axi.rresp, axi.bresp, axi.bid};
endmodule
